// File: rtl/qr_pkg.sv
// Shared types, defaults and helpers for the quarter-round engine.
package qr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int WORD_W_DEF = 8;
    localparam int ROT1_DEF   = 4;
    localparam int ROT2_DEF   = 3;
    localparam int ROT3_DEF   = 2;
    localparam int ROT4_DEF   = 1;

    // Step index within one quarter round (counter mod 4)
    localparam logic [1:0] STEP0 = 2'd0;
    localparam logic [1:0] STEP1 = 2'd1;
    localparam logic [1:0] STEP2 = 2'd2;
    localparam logic [1:0] STEP3 = 2'd3;

    // Rotate-left of the low w bits of x by r (1 <= r < w <= 64)
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned r,
                                         input int unsigned w);
        logic [63:0] m;
        logic [63:0] xm;
        m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm = x & m;
        return ((xm << r) | (xm >> (w - r))) & m;
    endfunction

endpackage

// File: rtl/qr_if.sv
// Job/result handshake bundle between a producer and the quarter-round engine.
interface qr_if
    import qr_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_ff;
    logic [WORD_W-1:0] in_a, in_b, in_c, in_d;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_a, out_b, out_c, out_d;

    modport master (
        output in_valid, in_ff, in_a, in_b, in_c, in_d, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d
    );

    modport slave (
        input  in_valid, in_ff, in_a, in_b, in_c, in_d, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_d
    );
endinterface

// File: rtl/qr_halfstep.sv
// One ARX half step: x' = x + y, z' = (z ^ x') <<< r. Purely combinational.
module qr_halfstep
    import qr_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] y_i,
    input  logic [WORD_W-1:0] z_i,
    input  int unsigned       r_i,
    output logic [WORD_W-1:0] x_o,
    output logic [WORD_W-1:0] z_o
);
    assign x_o = x_i + y_i;
    assign z_o = WORD_W'(rotl(64'(z_i ^ x_o), r_i, WORD_W));
endmodule

// File: rtl/qr_engine.sv
// Iterative quarter-round engine: one ARX step per clock, optional feed-forward,
// result held on a valid/ready output until consumed.
module qr_engine
    import qr_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ITER   = 2,
    parameter int ROT1   = ROT1_DEF,
    parameter int ROT2   = ROT2_DEF,
    parameter int ROT3   = ROT3_DEF,
    parameter int ROT4   = ROT4_DEF
) (
    input  logic clk,
    input  logic rst_n,
    qr_if.slave  bus,
    output logic busy
);
    localparam int STEPS = 4 * ITER;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef logic [WORD_W-1:0] word_t;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    word_t             a_q, b_q, c_q, d_q;
    word_t             sa_q, sb_q, sc_q, sd_q;
    logic              ff_q;
    word_t             oa_q, ob_q, oc_q, od_q;
    logic              out_valid_q;

    word_t             a_d, b_d, c_d, d_d;
    word_t             hx, hy, hz, hx_o, hz_o;
    int unsigned       hr;
    logic [1:0]        step;
    logic              accept;

    assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign busy          = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = oa_q;
    assign bus.out_b     = ob_q;
    assign bus.out_c     = oc_q;
    assign bus.out_d     = od_q;
    assign step          = cnt_q[1:0];

    // Route word roles and rotation to the shared half step: even steps mix (a,b,d), odd (c,d,b)
    always_comb begin
        hx = a_q;
        hy = b_q;
        hz = d_q;
        hr = ROT1;
        case (step)
            STEP0:   hr = ROT1;
            STEP1:   begin hx = c_q; hy = d_q; hz = b_q; hr = ROT2; end
            STEP2:   hr = ROT3;
            default: begin hx = c_q; hy = d_q; hz = b_q; hr = ROT4; end
        endcase
    end

    qr_halfstep #(.WORD_W(WORD_W)) u_half (
        .x_i (hx),
        .y_i (hy),
        .z_i (hz),
        .r_i (hr),
        .x_o (hx_o),
        .z_o (hz_o)
    );

    // Write the half-step results back into the roles they came from
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        if (!step[0]) begin
            a_d = hx_o;
            d_d = hz_o;
        end else begin
            c_d = hx_o;
            b_d = hz_o;
        end
    end

    // Job FSM: accept (also from DONE on the consuming edge), step, then hold the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0; b_q  <= '0; c_q  <= '0; d_q  <= '0;
            sa_q        <= '0; sb_q <= '0; sc_q <= '0; sd_q <= '0;
            ff_q        <= 1'b0;
            oa_q        <= '0; ob_q <= '0; oc_q <= '0; od_q <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            a_q  <= bus.in_a; b_q  <= bus.in_b; c_q  <= bus.in_c; d_q  <= bus.in_d;
            sa_q <= bus.in_a; sb_q <= bus.in_b; sc_q <= bus.in_c; sd_q <= bus.in_d;
            ff_q        <= bus.in_ff;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
                    if (cnt_q == LAST) begin
                        state_q     <= ST_DONE;
                        oa_q        <= ff_q ? a_d + sa_q : a_d;
                        ob_q        <= ff_q ? b_d + sb_q : b_d;
                        oc_q        <= ff_q ? c_d + sc_q : c_d;
                        od_q        <= ff_q ? d_d + sd_q : d_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_engine.sv
// Bench for qr_engine: directed vectors on two configurations plus a randomised
// stall regression over several word widths / round counts, all checked against
// a quarter-round reference model.
module tb_qr_engine;
    localparam int NCFG = 8;
    localparam int CW [NCFG] = '{8, 8, 4, 4, 8, 8, 16, 16};
    localparam int CI [NCFG] = '{1, 2, 1, 3, 1, 3, 1, 3};
    localparam int JOBS = 170;

    typedef struct { logic [63:0] a, b, c, d; } res_t;

    logic            clk = 1'b0;
    logic [NCFG-1:0] rst_n;
    int              vectors = 0;
    int              miscompares = 0;
    bit              done_f [NCFG];

    always #5 clk = ~clk;

    function automatic logic [63:0] rl(input logic [63:0] x, input int r, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        x = x & m;
        return ((x << r) | (x >> (w - r))) & m;
    endfunction

    // Reference: ITER plain quarter rounds, then optional add of the inputs
    task automatic model(input int w, input int it, input logic [63:0] ia, ib, ic, id,
                         input logic ff, output res_t r);
        logic [63:0] m, a, b, c, d;
        m = (64'd1 << w) - 64'd1;
        a = ia; b = ib; c = ic; d = id;
        for (int i = 0; i < it; i++) begin
            a = (a + b) & m; d = rl(d ^ a, 4, w);
            c = (c + d) & m; b = rl(b ^ c, 3, w);
            a = (a + b) & m; d = rl(d ^ a, 2, w);
            c = (c + d) & m; b = rl(b ^ c, 1, w);
        end
        if (ff) begin
            a = (a + ia) & m; b = (b + ib) & m; c = (c + ic) & m; d = (d + id) & m;
        end
        r.a = a; r.b = b; r.c = c; r.d = d;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = CW[g];
        localparam int IT = CI[g];

        qr_if #(.WORD_W(W)) bus ();
        logic busy;

        qr_engine #(.WORD_W(W), .ITER(IT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n[g]),
            .bus   (bus),
            .busy  (busy)
        );

        res_t q[$];
        int   n_in = 0, n_out = 0, since = 0;
        bit   pending = 1'b0;

        // Compare process: every valid cycle against the oldest outstanding job
        always @(negedge clk) begin
            res_t r;
            if (!rst_n[g]) begin
                q.delete();
                pending = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    if (pending) begin
                        chk($sformatf("latency[%0d]", g), since, 4 * IT);
                        pending = 1'b0;
                    end
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_valid[%0d]: got out_valid=1 expected no result", g);
                    end else begin
                        chk($sformatf("out_a[%0d]", g), 64'(bus.out_a), q[0].a);
                        chk($sformatf("out_b[%0d]", g), 64'(bus.out_b), q[0].b);
                        chk($sformatf("out_c[%0d]", g), 64'(bus.out_c), q[0].c);
                        chk($sformatf("out_d[%0d]", g), 64'(bus.out_d), q[0].d);
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            n_out++;
                        end
                    end
                end else if (pending) begin
                    since++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    model(W, IT, 64'(bus.in_a), 64'(bus.in_b), 64'(bus.in_c), 64'(bus.in_d),
                          bus.in_ff, r);
                    q.push_back(r);
                    n_in++;
                    pending = 1'b1;
                    since   = 0;
                end
            end
        end

        if (g >= 2) begin : g_rnd
            initial begin
                bus.out_ready = 1'b0;
                forever begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end

            initial begin
                bit acc;
                int t;
                bus.in_valid = 1'b0; bus.in_ff = 1'b0;
                bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
                while (!rst_n[g]) @(posedge clk);
                @(posedge clk); #1;
                for (int j = 0; j < JOBS; j++) begin
                    bus.in_valid = 1'b1;
                    bus.in_ff = 1'($urandom_range(0, 1));
                    bus.in_a = W'($urandom); bus.in_b = W'($urandom);
                    bus.in_c = W'($urandom); bus.in_d = W'($urandom);
                    t = 0;
                    do begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        t++;
                    end while (!acc && t < 200);
                    if (!acc) chk($sformatf("accept_timeout[%0d]", g), 0, 1);
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                    bus.in_a = W'($urandom);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                t = 0;
                while (q.size() != 0 && t < 500) begin @(negedge clk); t++; end
                chk($sformatf("jobs_in[%0d]", g), n_in, JOBS);
                chk($sformatf("jobs_out[%0d]", g), n_out, n_in);
                done_f[g] = 1'b1;
            end
        end
    end

    logic [31:0] o0, o1;
    assign o0 = {g_cfg[0].bus.out_a, g_cfg[0].bus.out_b, g_cfg[0].bus.out_c, g_cfg[0].bus.out_d};
    assign o1 = {g_cfg[1].bus.out_a, g_cfg[1].bus.out_b, g_cfg[1].bus.out_c, g_cfg[1].bus.out_d};

    initial begin : main
        res_t m;
        int   t;
        bit   seen, all;
        rst_n = '0;
        g_cfg[0].bus.in_valid = 1'b0; g_cfg[0].bus.in_ff = 1'b0; g_cfg[0].bus.out_ready = 1'b0;
        g_cfg[0].bus.in_a = 8'h00; g_cfg[0].bus.in_b = 8'h00;
        g_cfg[0].bus.in_c = 8'h00; g_cfg[0].bus.in_d = 8'h00;
        g_cfg[1].bus.in_valid = 1'b0; g_cfg[1].bus.in_ff = 1'b0; g_cfg[1].bus.out_ready = 1'b0;
        g_cfg[1].bus.in_a = 8'h00; g_cfg[1].bus.in_b = 8'h00;
        g_cfg[1].bus.in_c = 8'h00; g_cfg[1].bus.in_d = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = '1;

        // Reset state
        chk("rst_out_valid", g_cfg[0].bus.out_valid, 0);
        chk("rst_busy", g_cfg[0].busy, 0);
        chk("rst_in_ready", g_cfg[0].bus.in_ready, 1);
        chk("rst_outs", o0, 0);

        // Hand-computed pins for the reference model
        model(8, 1, 1, 2, 3, 4, 1'b0, m);
        chk("pin_ff0", {m.a[7:0], m.b[7:0], m.c[7:0], m.d[7:0]}, 32'h8ECB6EFB);
        model(8, 1, 1, 2, 3, 4, 1'b1, m);
        chk("pin_ff1", {m.a[7:0], m.b[7:0], m.c[7:0], m.d[7:0]}, 32'h8FCD71FF);
        model(8, 2, 0, 0, 0, 0, 1'b1, m);
        chk("pin_zero", {m.a[7:0], m.b[7:0], m.c[7:0], m.d[7:0]}, 32'h0);

        // ITER=1, (01,02,03,04), ff=0, output held back
        g_cfg[0].bus.in_a = 8'h01; g_cfg[0].bus.in_b = 8'h02;
        g_cfg[0].bus.in_c = 8'h03; g_cfg[0].bus.in_d = 8'h04;
        g_cfg[0].bus.in_valid = 1'b1;
        @(posedge clk); #1;
        g_cfg[0].bus.in_valid = 1'b0;
        g_cfg[0].bus.in_a = 8'hAA; g_cfg[0].bus.in_d = 8'h55;
        t = 0;
        while (!g_cfg[0].bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
        chk("lat_ff0", t, 4);
        chk("out_ff0", o0, 32'h8ECB6EFB);
        chk("done_busy", g_cfg[0].busy, 1);
        chk("done_in_ready_stall", g_cfg[0].bus.in_ready, 0);

        // Backpressure: result and valid held, no acceptance
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {g_cfg[0].bus.out_valid, o0}, {1'b1, 32'h8ECB6EFB});
            chk("bp_in_ready", g_cfg[0].bus.in_ready, 0);
        end

        // Same-edge consume and accept of the ff=1 job
        g_cfg[0].bus.in_a = 8'h01; g_cfg[0].bus.in_b = 8'h02;
        g_cfg[0].bus.in_c = 8'h03; g_cfg[0].bus.in_d = 8'h04;
        g_cfg[0].bus.in_ff = 1'b1; g_cfg[0].bus.in_valid = 1'b1;
        g_cfg[0].bus.out_ready = 1'b1;
        #1 chk("done_in_ready", g_cfg[0].bus.in_ready, 1);
        @(posedge clk); #1;
        g_cfg[0].bus.in_valid = 1'b0; g_cfg[0].bus.out_ready = 1'b0;
        chk("consume_drop", g_cfg[0].bus.out_valid, 0);
        chk("consume_busy", g_cfg[0].busy, 1);
        t = 0;
        while (!g_cfg[0].bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
        chk("lat_ff1", t, 4);
        chk("out_ff1", o0, 32'h8FCD71FF);

        // Consume without a new job: back to idle, outputs keep last value
        g_cfg[0].bus.out_ready = 1'b1;
        @(posedge clk); #1;
        g_cfg[0].bus.out_ready = 1'b0;
        chk("idle_valid", g_cfg[0].bus.out_valid, 0);
        chk("idle_busy", g_cfg[0].busy, 0);
        chk("idle_outs_hold", o0, 32'h8FCD71FF);

        // Reset two edges into RUN: job silently abandoned
        g_cfg[0].bus.in_a = 8'h11; g_cfg[0].bus.in_b = 8'h22;
        g_cfg[0].bus.in_valid = 1'b1;
        @(posedge clk); #1;
        g_cfg[0].bus.in_valid = 1'b0;
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        chk("abort_valid", g_cfg[0].bus.out_valid, 0);
        chk("abort_busy", g_cfg[0].busy, 0);
        chk("abort_in_ready", g_cfg[0].bus.in_ready, 1);
        chk("abort_outs", o0, 0);
        g_cfg[0].bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (g_cfg[0].bus.out_valid) seen = 1'b1; end
        chk("abort_no_result", seen, 0);

        // ITER=2, all-zero input with feed-forward
        g_cfg[1].bus.in_ff = 1'b1; g_cfg[1].bus.in_valid = 1'b1;
        @(posedge clk); #1;
        g_cfg[1].bus.in_valid = 1'b0;
        t = 0;
        while (!g_cfg[1].bus.out_valid && t < 30) begin @(posedge clk); #1; t++; end
        chk("lat_zero", t, 8);
        chk("out_zero", {g_cfg[1].bus.out_valid, o1}, {1'b1, 32'h0});
        g_cfg[1].bus.out_ready = 1'b1;
        @(posedge clk); #1;
        g_cfg[1].bus.out_ready = 1'b0;

        done_f[0] = 1'b1;
        done_f[1] = 1'b1;
        t = 0;
        do begin
            @(posedge clk);
            t++;
            all = 1'b1;
            for (int k = 0; k < NCFG; k++) if (!done_f[k]) all = 1'b0;
        end while (!all && t < 60000);
        if (!all) chk("regression_timeout", 0, 1);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
